// File: rtl/wb_stage_pipe_if.sv
// Handshake and data bundle between the MEM stage, the write-back stage and the
// register-file write port. master = MEM side / producer, slave = write-back stage.
interface wb_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] pc;
  logic [15:0]       imm16;
  logic [RD_W-1:0]   rd;
  logic              mem_to_reg;
  logic              lhi;
  logic              link;
  logic              lb;
  logic              lh;
  logic              load_extend;
  logic [OFF_W-1:0]  byte_off;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              wb_en;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              misalign;
  logic              mem_timeout;

  modport master (
    output in_valid, alu_out, pc, imm16, rd, mem_to_reg, lhi, link, lb, lh,
           load_extend, byte_off, mem_rdata, mem_rvalid,
    input  in_ready, wb_en, wb_rd, wb_data, misalign, mem_timeout
  );

  modport slave (
    input  in_valid, alu_out, pc, imm16, rd, mem_to_reg, lhi, link, lb, lh,
           load_extend, byte_off, mem_rdata, mem_rvalid,
    output in_ready, wb_en, wb_rd, wb_data, misalign, mem_timeout
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: picks the register-file write value, waits a bounded
// number of cycles for late load data, and flags misaligned or timed-out loads.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   S_IDLE     | ready; an accepted instruction with data on hand writes back
//              | next cycle
//   S_WAIT_MEM | load captured, waiting for mem_rvalid; counts idle cycles up
//              | to WAIT_MAX
module wb_stage_pipe #(
  parameter int DATA_W      = 32,
  parameter int RD_W        = 5,
  parameter int LINK_OFFSET = 8,
  parameter int WAIT_MAX    = 15
) (
  input  logic            clk,
  input  logic            reset,
  wb_stage_pipe_if.slave  bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;

  logic [DATA_W-1:0] r_cap_alu;
  logic [DATA_W-1:0] r_cap_pc;
  logic [15:0]       r_cap_imm16;
  logic [RD_W-1:0]   r_cap_rd;
  logic              r_cap_mtr;
  logic              r_cap_lhi;
  logic              r_cap_link;
  logic              r_cap_lb;
  logic              r_cap_lh;
  logic              r_cap_ext;
  logic [OFF_W-1:0]  r_cap_off;

  logic              r_wb_en;
  logic [RD_W-1:0]   r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_misalign;
  logic              r_timeout;

  logic              w_in_wait;
  logic [DATA_W-1:0] w_op_alu;
  logic [DATA_W-1:0] w_op_pc;
  logic [15:0]       w_op_imm16;
  logic [RD_W-1:0]   w_op_rd;
  logic              w_op_mtr;
  logic              w_op_lhi;
  logic              w_op_link;
  logic              w_op_lb;
  logic              w_op_lh;
  logic              w_op_ext;
  logic [OFF_W-1:0]  w_op_off;

  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_load_val;
  logic              w_load_mis;
  logic [DATA_W-1:0] w_result;
  logic              w_misalign;

  logic              w_fire;
  logic              w_capture;
  logic              w_cnt_inc;
  logic              w_timeout;
  logic [7:0]        w_cnt_nxt;

  assign w_in_wait = (r_state == S_WAIT_MEM);

  // While waiting, the result is built from the captured operands; otherwise from live inputs.
  assign w_op_alu   = w_in_wait ? r_cap_alu   : bus.alu_out;
  assign w_op_pc    = w_in_wait ? r_cap_pc    : bus.pc;
  assign w_op_imm16 = w_in_wait ? r_cap_imm16 : bus.imm16;
  assign w_op_rd    = w_in_wait ? r_cap_rd    : bus.rd;
  assign w_op_mtr   = w_in_wait ? r_cap_mtr   : bus.mem_to_reg;
  assign w_op_lhi   = w_in_wait ? r_cap_lhi   : bus.lhi;
  assign w_op_link  = w_in_wait ? r_cap_link  : bus.link;
  assign w_op_lb    = w_in_wait ? r_cap_lb    : bus.lb;
  assign w_op_lh    = w_in_wait ? r_cap_lh    : bus.lh;
  assign w_op_ext   = w_in_wait ? r_cap_ext   : bus.load_extend;
  assign w_op_off   = w_in_wait ? r_cap_off   : bus.byte_off;

  // Shifting the addressed lane down to bit 0 serves byte, halfword and (offset 0) word loads.
  assign w_shift = bus.mem_rdata >> {w_op_off, 3'b000};

  // Load alignment/extraction and write-value select (lhi > link > load > alu).
  always_comb begin
    w_load_val = w_shift;
    w_load_mis = 1'b0;
    if (w_op_lh) begin
      w_load_mis = w_op_off[0];
      w_load_val = w_op_ext ? {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]}
                            : {{(DATA_W-16){1'b0}}, w_shift[15:0]};
    end else if (w_op_lb) begin
      w_load_val = w_op_ext ? {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]}
                            : {{(DATA_W-8){1'b0}}, w_shift[7:0]};
    end else begin
      w_load_mis = |w_op_off;
    end

    w_misalign = 1'b0;
    if (w_op_lhi) begin
      w_result = DATA_W'({w_op_imm16, 16'h0000});
    end else if (w_op_link) begin
      w_result = w_op_pc + DATA_W'(LINK_OFFSET);
    end else if (w_op_mtr) begin
      w_result   = w_load_val;
      w_misalign = w_load_mis;
    end else begin
      w_result = w_op_alu;
    end
  end

  assign w_cnt_nxt = r_cnt + 8'd1;

  // Next state and per-cycle actions: fire a result, capture a load, count, or time out.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_capture   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.mem_to_reg && !bus.mem_rvalid) begin
            w_capture   = 1'b1;
            w_state_nxt = S_WAIT_MEM;
          end else begin
            w_fire = 1'b1;
          end
        end
      end
      S_WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          w_fire      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_cnt_nxt == 8'(WAIT_MAX)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Wait counter and captured operands of a load that is waiting for data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_cap_alu   <= '0;
      r_cap_pc    <= '0;
      r_cap_imm16 <= '0;
      r_cap_rd    <= '0;
      r_cap_mtr   <= 1'b0;
      r_cap_lhi   <= 1'b0;
      r_cap_link  <= 1'b0;
      r_cap_lb    <= 1'b0;
      r_cap_lh    <= 1'b0;
      r_cap_ext   <= 1'b0;
      r_cap_off   <= '0;
    end else if (w_capture) begin
      r_cnt       <= '0;
      r_cap_alu   <= bus.alu_out;
      r_cap_pc    <= bus.pc;
      r_cap_imm16 <= bus.imm16;
      r_cap_rd    <= bus.rd;
      r_cap_mtr   <= bus.mem_to_reg;
      r_cap_lhi   <= bus.lhi;
      r_cap_link  <= bus.link;
      r_cap_lb    <= bus.lb;
      r_cap_lh    <= bus.lh;
      r_cap_ext   <= bus.load_extend;
      r_cap_off   <= bus.byte_off;
    end else if (w_cnt_inc) begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Registered outputs; R0 writes are suppressed, wb_rd/wb_data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_en    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_wb_en    <= 1'b0;
      r_misalign <= 1'b0;
      r_timeout  <= w_timeout;
      if (w_fire) begin
        if (w_misalign) begin
          r_misalign <= 1'b1;
        end else if (w_op_rd != '0) begin
          r_wb_en   <= 1'b1;
          r_wb_rd   <= w_op_rd;
          r_wb_data <= w_result;
        end
      end
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.wb_en       = r_wb_en;
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_data     = r_wb_data;
  assign bus.misalign    = r_misalign;
  assign bus.mem_timeout = r_timeout;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: single-cycle vectors from a table, then hand-written
// sequences for waiting loads, timeout and reset. Every output event is matched
// against a queue of expected events.
module tb_wb_stage_pipe;
  localparam int WAIT_MAX = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  wb_stage_pipe_if #(.DATA_W(32), .RD_W(5)) bus ();

  wb_stage_pipe #(
    .DATA_W(32), .RD_W(5), .LINK_OFFSET(8), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic        mtr;
    logic        lhi;
    logic        link;
    logic        lb;
    logic        lh;
    logic        ext;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [2:0]  exp_flags;   // {wb_en, misalign, mem_timeout}
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [2:0]  flags;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] pc,
                              input logic [15:0] imm, input logic [4:0] rd,
                              input logic mtr, input logic lhi, input logic link,
                              input logic lb, input logic lh, input logic ext,
                              input logic [1:0] off, input logic [31:0] rdata,
                              input logic [2:0] fl, input logic [31:0] d);
    vec_t v;
    v.alu = alu; v.pc = pc; v.imm = imm; v.rd = rd; v.mtr = mtr; v.lhi = lhi;
    v.link = link; v.lb = lb; v.lh = lh; v.ext = ext; v.off = off; v.rdata = rdata;
    v.exp_flags = fl; v.exp_data = d;
    return v;
  endfunction

  task automatic push(input logic [2:0] fl, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.flags = fl; e.rd = rd; e.data = d;
    sb.push_back(e);
  endtask

  task automatic drive(input vec_t v, input logic valid, input logic rvalid);
    bus.in_valid    = valid;
    bus.alu_out     = v.alu;
    bus.pc          = v.pc;
    bus.imm16       = v.imm;
    bus.rd          = v.rd;
    bus.mem_to_reg  = v.mtr;
    bus.lhi         = v.lhi;
    bus.link        = v.link;
    bus.lb          = v.lb;
    bus.lh          = v.lh;
    bus.load_extend = v.ext;
    bus.byte_off    = v.off;
    bus.mem_rdata   = v.rdata;
    bus.mem_rvalid  = rvalid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output event must match the oldest expected event.
  always @(negedge clk) begin
    logic [2:0] got;
    exp_t       e;
    if (!reset) begin
      got = {bus.wb_en, bus.misalign, bus.mem_timeout};
      if (got != 3'b000) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 32'(got), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("event_flags", 32'(got), 32'(e.flags));
          if (e.flags[2]) begin
            chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
            chk("wb_data", bus.wb_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    vec_t v;
    int   n;

    //            alu           pc            imm      rd     mtr lhi lnk lb lh ext off rdata         flags   data
    tbl[0]  = mk(32'h1234_5678, 32'h0,        16'h0,    5'd3,  0, 0, 0, 0, 0, 0, 2'd0, 32'h0,        3'b100, 32'h1234_5678);
    tbl[1]  = mk(32'h0,         32'h0,        16'h0,    5'd4,  1, 0, 0, 1, 0, 1, 2'd2, 32'h0080_0000, 3'b100, 32'hFFFF_FF80);
    tbl[2]  = mk(32'h0,         32'h0,        16'h0,    5'd5,  1, 0, 0, 1, 0, 0, 2'd2, 32'h0080_0000, 3'b100, 32'h0000_0080);
    tbl[3]  = mk(32'h0,         32'h0,        16'h0,    5'd6,  1, 0, 0, 0, 1, 1, 2'd1, 32'h1111_2222, 3'b010, 32'h0);
    tbl[4]  = mk(32'h0,         32'h0,        16'h0,    5'd7,  1, 0, 0, 0, 1, 1, 2'd2, 32'h8001_0000, 3'b100, 32'hFFFF_8001);
    tbl[5]  = mk(32'h0,         32'h40,       16'hABCD, 5'd8,  0, 1, 1, 0, 0, 0, 2'd0, 32'h0,        3'b100, 32'hABCD_0000);
    tbl[6]  = mk(32'h0,         32'hFFFF_FFFC, 16'h0,   5'd9,  0, 0, 1, 0, 0, 0, 2'd0, 32'h0,        3'b100, 32'h0000_0004);
    tbl[7]  = mk(32'h0,         32'h0,        16'h0,    5'd10, 1, 0, 0, 0, 0, 0, 2'd0, 32'hDEAD_BEEF, 3'b100, 32'hDEAD_BEEF);
    tbl[8]  = mk(32'h0,         32'h0,        16'h0,    5'd11, 1, 0, 0, 0, 0, 0, 2'd1, 32'hDEAD_BEEF, 3'b010, 32'h0);
    tbl[9]  = mk(32'h0,         32'h0,        16'h0,    5'd12, 1, 0, 0, 1, 0, 1, 2'd3, 32'h7F00_0000, 3'b100, 32'h0000_007F);
    tbl[10] = mk(32'h0,         32'h0,        16'h0,    5'd13, 1, 0, 0, 0, 1, 0, 2'd0, 32'h0000_ABCD, 3'b100, 32'h0000_ABCD);
    tbl[11] = mk(32'h9999_9999, 32'h0,        16'h0,    5'd0,  0, 0, 0, 0, 0, 0, 2'd0, 32'h0,        3'b000, 32'h0);
    tbl[12] = mk(32'h0,         32'h0,        16'h0,    5'd0,  1, 0, 0, 0, 1, 0, 2'd3, 32'h0,        3'b010, 32'h0);
    tbl[13] = mk(32'h0,         32'h0,        16'h1234, 5'd14, 1, 1, 0, 0, 0, 0, 2'd0, 32'h5555_5555, 3'b100, 32'h1234_0000);
    tbl[14] = mk(32'h0,         32'h100,      16'h0,    5'd15, 1, 0, 1, 0, 0, 0, 2'd0, 32'h5555_5555, 3'b100, 32'h0000_0108);

    v = mk(32'h0, 32'h0, 16'h0, 5'd0, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0, 3'b000, 32'h0);
    drive(v, 1'b0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_en", 32'(bus.wb_en), 32'h0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'h0);
    chk("rst_wb_data", bus.wb_data, 32'h0);
    chk("rst_misalign", 32'(bus.misalign), 32'h0);
    chk("rst_timeout", 32'(bus.mem_timeout), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    reset = 1'b0;
    step();

    // Table vectors, back to back, data always on hand.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i], 1'b1, 1'b1);
      chk("tbl_in_ready", 32'(bus.in_ready), 32'h1);
      if (tbl[i].exp_flags != 3'b000) push(tbl[i].exp_flags, tbl[i].rd, tbl[i].exp_data);
      step();
    end
    drive(v, 1'b0, 1'b0);
    step();

    // Four back-to-back ALU writes land on four consecutive cycles.
    for (int j = 0; j < 4; j++) begin
      v = mk(32'hA000_0000 + 32'(j), 32'h0, 16'h0, 5'(j + 1), 0, 0, 0, 0, 0, 0, 2'd0,
             32'h0, 3'b100, 32'h0);
      drive(v, 1'b1, 1'b0);
      push(3'b100, 5'(j + 1), 32'hA000_0000 + 32'(j));
      step();
      chk("b2b_wb_en", 32'(bus.wb_en), 32'h1);
    end
    drive(v, 1'b0, 1'b0);
    step();

    // Load with data arriving late: rvalid low in accept cycle and two wait cycles.
    v = mk(32'h0, 32'h0, 16'h0, 5'd14, 1, 0, 0, 0, 0, 0, 2'd0, 32'h0, 3'b100, 32'h0);
    drive(v, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("wait_in_ready", 32'(bus.in_ready), 32'h0);
      chk("wait_wb_en", 32'(bus.wb_en), 32'h0);
      if (k == 2) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        push(3'b100, 5'd14, 32'hCAFE_F00D);
      end
      step();
    end
    bus.mem_rvalid = 1'b0;
    chk("late_wb_data", bus.wb_data, 32'hCAFE_F00D);
    chk("late_in_ready", 32'(bus.in_ready), 32'h1);
    step();

    // Misaligned halfword that also waits: misalign reported once data arrives.
    v = mk(32'h0, 32'h0, 16'h0, 5'd17, 1, 0, 0, 0, 1, 1, 2'd1, 32'h0, 3'b010, 32'h0);
    drive(v, 1'b1, 1'b0);
    step();
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b1;
    push(3'b010, 5'd0, 32'h0);
    step();
    bus.mem_rvalid = 1'b0;
    chk("mis_wait_pulse", 32'(bus.misalign), 32'h1);
    chk("mis_wait_no_wb", 32'(bus.wb_en), 32'h0);
    step();

    // Timeout: rvalid never comes; in_ready low for exactly WAIT_MAX cycles.
    v = mk(32'h0, 32'h0, 16'h0, 5'd18, 1, 0, 0, 0, 0, 0, 2'd0, 32'h0, 3'b001, 32'h0);
    drive(v, 1'b1, 1'b0);
    push(3'b001, 5'd0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.in_ready == 1'b0 && n < 100) begin
      n++;
      step();
    end
    chk("timeout_wait_cycles", 32'(n), 32'(WAIT_MAX));
    chk("timeout_pulse", 32'(bus.mem_timeout), 32'h1);
    step();

    // Reset mid-wait: outputs clear at once and a late rvalid writes nothing.
    v = mk(32'h55AA_55AA, 32'h0, 16'h0, 5'd20, 0, 0, 0, 0, 0, 0, 2'd0, 32'h0, 3'b100, 32'h0);
    drive(v, 1'b1, 1'b0);
    push(3'b100, 5'd20, 32'h55AA_55AA);
    step();
    v = mk(32'h0, 32'h0, 16'h0, 5'd21, 1, 0, 0, 0, 0, 0, 2'd0, 32'h0, 3'b000, 32'h0);
    drive(v, 1'b1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_in_ready", 32'(bus.in_ready), 32'h0);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_wb_data", bus.wb_data, 32'h0);
    chk("async_rst_wb_rd", 32'(bus.wb_rd), 32'h0);
    chk("async_rst_wb_en", 32'(bus.wb_en), 32'h0);
    step();
    reset = 1'b0;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_1111;
    repeat (3) step();
    bus.mem_rvalid = 1'b0;
    chk("post_rst_wb_data", bus.wb_data, 32'h0);
    repeat (3) step();

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
